// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, round counts, widths and the
// byte-level helpers (S-box lookup, GF(2^8) doubling) used by the round logic.
package aes_pkg;

    localparam int BLK_W  = 128;
    localparam int RND_W  = 4;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes256_round.sv
// One combinational AES round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
// final_rnd bypasses MixColumns for the last round. Byte 0 sits in bits
// [127:120]; byte index = 4*column + row.
module aes256_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] st_in,
    input  logic [BLK_W-1:0] rk,
    input  logic             final_rnd,
    output logic [BLK_W-1:0] st_out
);

    logic [7:0] w_sb [16];
    logic [7:0] w_sr [16];
    logic [7:0] w_mc [16];

    genvar gi;

    // SubBytes per byte, then ShiftRows: row r of column c takes column (c+r)%4.
    for (gi = 0; gi < 16; gi++) begin : g_sub_shift
        assign w_sb[gi] = sbox(st_in[BLK_W-1-8*gi -: 8]);
        assign w_sr[gi] = w_sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    end

    // MixColumns on each of the four columns.
    for (gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[4*gi+0];
        assign w_a1 = w_sr[4*gi+1];
        assign w_a2 = w_sr[4*gi+2];
        assign w_a3 = w_sr[4*gi+3];
        assign w_mc[4*gi+0] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
        assign w_mc[4*gi+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
        assign w_mc[4*gi+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
        assign w_mc[4*gi+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    // AddRoundKey, selecting the MixColumns bypass on the final round.
    for (gi = 0; gi < 16; gi++) begin : g_ark
        assign st_out[BLK_W-1-8*gi -: 8] = (final_rnd ? w_sr[gi] : w_mc[gi])
                                           ^ rk[BLK_W-1-8*gi -: 8];
    end

endmodule

// File: rtl/aes256_enc_ctrl.sv
// Iterative AES encryption sequencer: one round per consumed round key,
// keys fetched by index from an external schedule store, ciphertext held
// on a ready/valid port until taken or aborted.
module aes256_enc_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_256
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_block,
    input  logic             abort,
    output logic             rk_req,
    output logic [RND_W-1:0] rk_idx,
    input  logic             rk_valid,
    input  logic [BLK_W-1:0] rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_block,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic [RND_W-1:0] r_rnd;
    logic [BLK_W-1:0] r_st;
    logic [BLK_W-1:0] r_out_block;

    logic             w_accept;
    logic             w_consume;
    logic             w_last;
    logic [BLK_W-1:0] w_round_out;

    assign w_accept  = (r_state == IDLE) && in_valid;
    // A key is only taken in ROUND; abort suppresses it so nothing lands.
    assign w_consume = (r_state == ROUND) && rk_valid && !abort;
    assign w_last    = (r_rnd == RND_W'(NR));

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rk_req    = (r_state == ROUND);
    assign out_valid = (r_state == DONE);
    assign rk_idx    = r_rnd;
    assign out_block = r_out_block;

    aes256_round u_round (
        .st_in     (r_st),
        .rk        (rk),
        .final_rnd (w_last),
        .st_out    (w_round_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; abort takes priority over the final key and out_ready.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = ROUND;
                end
            end
            ROUND: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (rk_valid && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Round counter, working state and ciphertext register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rnd       <= '0;
            r_st        <= '0;
            r_out_block <= '0;
        end else if (w_accept) begin
            r_st  <= in_block;
            r_rnd <= '0;
        end else if (busy && abort) begin
            r_rnd <= '0;
        end else if (w_consume) begin
            if (w_last) begin
                r_out_block <= w_round_out;
                r_rnd       <= '0;
            end else begin
                // Round 0 is the bare key whitening; later rounds use the datapath.
                r_st  <= (r_rnd == '0) ? (r_st ^ rk) : w_round_out;
                r_rnd <= r_rnd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes256_enc_ctrl.sv
// Directed bench for aes256_enc_ctrl with a behavioural AES-256 key schedule
// answering rk_idx requests and a scoreboard queue of expected ciphertexts.
module tb_aes256_enc_ctrl;
    import aes_pkg::*;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_SP  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         abort;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;

    aes256_enc_ctrl #(.NR(NR_256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .abort     (abort),
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           t_acc    = 0;
    logic [127:0] exp_q [$];
    logic [127:0] rkeys [0:14];

    // Stall injection: three dead cycles at the start of rounds 2 and 13.
    logic stall_en;
    logic stall_clr;
    int   stall_cnt2;
    int   stall_cnt13;

    always_comb begin
        rk_valid = 1'b1;
        if (stall_en && rk_req) begin
            if (rk_idx == 4'd2 && stall_cnt2 < 3)   rk_valid = 1'b0;
            if (rk_idx == 4'd13 && stall_cnt13 < 3) rk_valid = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (stall_clr) begin
            stall_cnt2  <= 0;
            stall_cnt13 <= 0;
        end else if (rk_req && !rk_valid) begin
            if (rk_idx == 4'd2)  stall_cnt2  <= stall_cnt2 + 1;
            if (rk_idx == 4'd13) stall_cnt13 <= stall_cnt13 + 1;
        end
    end

    // Key store: junk on the bus whenever the key is not flagged valid.
    always_comb begin
        rk = 128'hdeadbeef_0badf00d_deadbeef_0badf00d;
        if (rk_valid && rk_idx <= 4'd14) rk = rkeys[rk_idx];
    end

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) rkeys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after acceptance.
    task automatic send(input logic [127:0] pt, input logic [127:0] ct);
        chk("in_ready_idle", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        in_block = pt;
        @(negedge clk);
        in_valid = 1'b0;
        in_block = {$urandom, $urandom, $urandom, $urandom};
        t_acc = cyc;
        exp_q.push_back(ct);
        chk("busy_after_accept", 128'(busy), 128'd1);
    endtask

    task automatic wait_out(input int budget, output int lat);
        int          n = 0;
        logic        was_stall = 1'b0;
        logic [3:0]  p_idx = '0;
        logic [127:0] p_st = '0;
        while (!out_valid && n < budget) begin
            if (rk_req && !rk_valid) begin
                if (was_stall) begin
                    chk("stall_rk_idx_hold", 128'(rk_idx), 128'(p_idx));
                    chk("stall_st_hold", dut.r_st, p_st);
                end
                was_stall = 1'b1;
                p_idx = rk_idx;
                p_st  = dut.r_st;
            end else begin
                was_stall = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk("out_valid_within_budget", 128'(out_valid), 128'd1);
        lat = cyc - t_acc;
    endtask

    task automatic wait_rk(input logic [3:0] idx, input int budget);
        int n = 0;
        while (!(rk_req && rk_idx == idx) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rk_idx", 128'({rk_req, rk_idx}), 128'({1'b1, idx}));
    endtask

    task automatic take_out(input string tag);
        logic [127:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_out_block"}, out_block, e);
        $display("beat %s: out_block=%h expected=%h", tag, out_block, e);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 128'(out_valid), 128'd0);
        chk({tag, "_in_ready_after"}, 128'(in_ready), 128'd1);
    endtask

    task automatic watch_quiet(input string tag, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk(tag, 128'(seen), 128'd0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        stall_en  = 1'b0;
        stall_clr = 1'b1;
        expand_key(KEY_C3);

        #12;
        chk("reset_in_ready",  128'(in_ready),  128'd1);
        chk("reset_busy",      128'(busy),      128'd0);
        chk("reset_rk_req",    128'(rk_req),    128'd0);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_block", out_block,       128'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        stall_clr = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 128'(in_ready), 128'd1);

        // Nominal C.3 block with keys always available.
        send(PT_C3, CT_C3);
        chk("round0_rk_idx", 128'(rk_idx), 128'd0);
        wait_out(40, lat);
        chk("c3_latency", 128'(lat), 128'd15);
        take_out("c3");

        // Same block with 3-cycle key stalls in rounds 2 and 13.
        stall_clr = 1'b1;
        @(negedge clk);
        stall_clr = 1'b0;
        stall_en  = 1'b1;
        send(PT_C3, CT_C3);
        wait_out(60, lat);
        chk("stall_latency", 128'(lat), 128'd21);
        chk("stall_cycles_r2",  128'(stall_cnt2),  128'd3);
        chk("stall_cycles_r13", 128'(stall_cnt13), 128'd3);
        take_out("stall");
        stall_en = 1'b0;

        // Output backpressure for five cycles, then back-to-back acceptance.
        send(PT_C3, CT_C3);
        wait_out(40, lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_block", out_block, CT_C3);
            chk("bp_in_ready",  128'(in_ready),  128'd0);
            @(negedge clk);
        end
        take_out("bp");
        send(PT_C3, CT_C3);
        wait_out(40, lat);
        chk("b2b_latency", 128'(lat), 128'd15);
        take_out("b2b");

        // Second vector under a different key.
        expand_key(KEY_SP);
        send(PT_SP, CT_SP);
        wait_out(40, lat);
        take_out("sp800");
        expand_key(KEY_C3);

        // Abort during round 7.
        send(PT_C3, CT_C3);
        wait_rk(4'd7, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(exp_q.pop_back());
        chk("abort7_busy",      128'(busy),      128'd0);
        chk("abort7_in_ready",  128'(in_ready),  128'd1);
        chk("abort7_out_valid", 128'(out_valid), 128'd0);
        watch_quiet("abort7_no_beat", 20);
        send(PT_C3, CT_C3);
        wait_out(40, lat);
        take_out("after_abort7");

        // Abort together with the final key and out_ready.
        send(PT_C3, CT_C3);
        wait_rk(4'd14, 30);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_back());
        chk("abort14_out_valid", 128'(out_valid), 128'd0);
        chk("abort14_busy",      128'(busy),      128'd0);
        chk("abort14_in_ready",  128'(in_ready),  128'd1);
        watch_quiet("abort14_no_beat", 20);

        // Abort in DONE together with out_ready.
        send(PT_C3, CT_C3);
        wait_out(40, lat);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_done_out_valid", 128'(out_valid), 128'd0);
        chk("abort_done_in_ready",  128'(in_ready),  128'd1);

        // Abort in IDLE is ignored; a simultaneous in_valid is taken.
        chk("idle_abort_in_ready", 128'(in_ready), 128'd1);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_block = PT_C3;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        t_acc    = cyc;
        exp_q.push_back(CT_C3);
        chk("idle_abort_accepted", 128'(busy), 128'd1);
        wait_out(40, lat);
        chk("idle_abort_latency", 128'(lat), 128'd15);
        take_out("idle_abort");

        // Asynchronous reset in the middle of a round.
        send(PT_C3, CT_C3);
        wait_rk(4'd5, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready",  128'(in_ready),  128'd1);
        chk("async_rst_busy",      128'(busy),      128'd0);
        chk("async_rst_rk_req",    128'(rk_req),    128'd0);
        chk("async_rst_rk_idx",    128'(rk_idx),    128'd0);
        chk("async_rst_out_valid", 128'(out_valid), 128'd0);
        chk("async_rst_out_block", out_block,       128'd0);
        exp_q.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        send(PT_C3, CT_C3);
        wait_out(40, lat);
        chk("post_rst_latency", 128'(lat), 128'd15);
        take_out("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes256_enc_ctrl.md
# aes256_enc_ctrl

Iterative AES-256 encryption sequencer. It accepts one 128-bit plaintext block and runs the single-round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) once per cycle for 14 rounds. It fetches round keys 0..14 from the external key-schedule store through an index/valid handshake and presents the ciphertext on a ready/valid output port. It sits between the sender's block framing logic and the key expansion unit; byte ordering is big-endian [0:127], column-major (byte 0 = row 0, column 0).

## Interface
- NR, 14, number of rounds; legal values 10, 12, 14; the round counter is 4 bits regardless.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext offered.
- in_ready  out  1  controller can accept plaintext (IDLE only).
- in_block  in  128  plaintext [0:127].
- abort  in  1  synchronous cancel of the block in flight.
- rk_req  out  1  round key requested (ROUND state).
- rk_idx  out  4  round key index requested, 0..NR.
- rk_valid  in  1  rk holds key rk_idx this cycle.
- rk  in  128  round key [0:127].
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes ciphertext.
- out_block  out  128  ciphertext [0:127].
- busy  out  1  not IDLE.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid: capture in_block into st, set rnd=0, go to ROUND.
- ROUND: rk_req=1, rk_idx=rnd. On a cycle with rk_valid=0, st and rnd hold (stall), with no limit on stall length.
- ROUND with rk_valid=1:
  - rnd=0: st ← st ^ rk.
  - 1 ≤ rnd ≤ NR−1: st ← full round(st, rk).
  - rnd=NR: out_block ← final round (MixColumns skipped); go to DONE.
  - rnd increments after each consumed key.
- DONE: out_valid=1, out_block stable. On out_ready, go to IDLE; out_valid drops the next cycle. The stored out_block may hold its value after the handshake.
- abort: in ROUND or DONE, go to IDLE on the next edge. Nothing is emitted and out_valid is 0 from the next cycle. abort wins over a simultaneous final key or out_ready. abort in IDLE is ignored, and a simultaneous in_valid is still accepted.
- Reset (asynchronous, any state): state=IDLE, rnd=0, st=0, out_block=0. in_ready=1 after release; rk_req, out_valid and busy are 0. A block in flight is lost.
- rk is sampled only when rk_req && rk_valid. Its value is a don't-care otherwise.

## Timing
- Acceptance at edge T (in_valid && in_ready). With rk_valid tied high, keys 0..NR are consumed at edges T+1..T+NR+1, and out_valid is high from T+NR+1 (T+15 for NR=14).
- Each stall cycle adds exactly one cycle of latency.
- Minimum block period is NR+3 cycles (17), assuming out_ready is high on the first DONE cycle.
- in_ready is registered-state decode only; it has no combinational path from in_valid. out_valid and rk_req are also state decodes.
- rk_idx changes only on edges where a key is consumed.

## Structure
- Shared package aes_pkg:
  - state encoding constants IDLE/ROUND/DONE
  - NR_128=10, NR_192=12, NR_256=14
  - block width 128, round index width 4
- Sub-module aes256_round: combinational, with ports st_in, rk, final_rnd and st_out. It chains the existing SubBytes, ShiftRows and MixColumns blocks plus the XOR; final_rnd bypasses MixColumns.
- The controller holds the FSM, rnd counter, st register and out_block register. Round-0 XOR is in the controller.

## Test plan
- FIPS-197 C.3 vector, with the key schedule model indexed by rk_idx and key 000102…1f:
  - plaintext 00112233445566778899aabbccddeeff → out_block 8ea2b7ca516745bfeafc49904b496089.
  - out_valid asserted exactly 15 cycles after acceptance.
- Same vector with rk_valid low for 3 random cycles during rounds 2 and 13 → same ciphertext, 6 cycles later; rk_idx and st held through each stall.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid and out_block stable throughout, in_ready=0. Handshake → IDLE; next block accepted the cycle after.
- abort in round 7:
  - busy=0 and in_ready=1 the next cycle; no out_valid.
  - A following block still yields correct ciphertext.
- abort coincident with key 14 and with out_ready → no output beat, return to IDLE.
- rst_n pulsed low mid-round (asynchronous, between edges) → outputs go to reset values immediately. After release, a full C.3 encryption passes.
